mem_io_responder: RTL and testbench

//   Responder end of the CPU byte-wide memory bus (addr/wr/dout from CPU, din back to CPU).

---
 rtl/mem_io_pkg.sv | 22 ++
 rtl/mem_io_responder_if.sv | 31 +++
 rtl/tx_byte_fifo.sv | 49 ++++
 rtl/mem_io_responder.sv | 132 +++++++++++++
 tb/tb_mem_io_responder.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_pkg.sv
// rtl/mem_io_pkg.sv - shared decode constants and types for the CPU memory/IO responder
// Purpose: IO address constants, region and read-source enums, and the region decoder.
// Ports: none (package).
package mem_io_pkg;

  localparam logic [17:0] IO_BASE = 18'h30000;
  localparam logic [2:0]  IO_UART = 3'd0;
  localparam logic [2:0]  IO_CLK  = 3'd4;

  typedef enum logic [1:0] {RG_RAM, RG_NONE, RG_IO} region_e;

  // Which registered source drives bus_rdata after a read.
  typedef enum logic [1:0] {RS_RAM, RS_RX, RS_CLK, RS_ZERO} rsrc_e;

  // a[17:16]: 00/01 RAM, 10 unmapped, 11 IO.
  function automatic region_e decode_region(input logic [1:0] hi);
    if (hi == IO_BASE[17:16]) return RG_IO;
    else if (!hi[1])          return RG_RAM;
    else                      return RG_NONE;
  endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// rtl/mem_io_responder_if.sv - CPU byte bus plus UART side-channel bundle
// Purpose: groups the CPU bus, UART TX/RX handshakes and status flags.
// Ports (signals): rdy_in, bus_a, bus_wr, bus_wdata, bus_rdata, io_buffer_full,
//   tx_data, tx_valid, tx_ready, rx_data, rx_valid, rx_ready, prog_stop, tx_overflow.
//   slave = responder side, master = CPU/UART/environment side.
interface mem_io_responder_if;
  logic        rdy_in;
  logic [31:0] bus_a;
  logic        bus_wr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_stop;
  logic        tx_overflow;

  modport slave (
    input  rdy_in, bus_a, bus_wr, bus_wdata, tx_ready, rx_data, rx_valid,
    output bus_rdata, io_buffer_full, tx_data, tx_valid, rx_ready, prog_stop, tx_overflow
  );

  modport master (
    output rdy_in, bus_a, bus_wr, bus_wdata, tx_ready, rx_data, rx_valid,
    input  bus_rdata, io_buffer_full, tx_data, tx_valid, rx_ready, prog_stop, tx_overflow
  );
endinterface

// File: rtl/tx_byte_fifo.sv
// rtl/tx_byte_fifo.sv - synchronous byte FIFO feeding the UART transmitter
// Purpose: DEPTH-entry byte queue with wrap-around pointers one bit wider than the index.
// Ports: clk_in, rst_in (async active-low), push_i/push_data_i, pop_i,
//   data_o (head byte), count_o, full_o, empty_o.
//   Push while full and pop while empty are ignored; simultaneous push and pop both happen.
module tx_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic push_ok, pop_ok;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count_o == DEPTH_C);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - responder for the CPU byte bus: RAM, UART port and clock/stop port
// Purpose: decodes CPU accesses into on-chip RAM, the UART TX FIFO / RX pass-through at
//   0x30000 and the cycle counter / program-stop port at 0x30004..7.
// Ports: clk_in, rst_in (async active-low), bus (mem_io_responder_if.slave) carrying the
//   CPU bus (rdy_in, bus_a, bus_wr, bus_wdata, bus_rdata), UART TX (tx_data/tx_valid/tx_ready),
//   UART RX (rx_data/rx_valid/rx_ready) and status (io_buffer_full, prog_stop, tx_overflow).
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  mem_io_responder_if.slave   bus
);

  localparam int CW = $clog2(TX_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = TX_DEPTH[CW-1:0];
  localparam logic [CW-1:0] MARGIN_C = FULL_MARGIN[CW-1:0];

  logic [7:0]  ram_mem [2**RAM_AW];
  logic [7:0]  ram_rd_q;
  rsrc_e       rs_q, rs_d;
  logic [7:0]  io_q, io_d;
  logic [31:0] cnt_q, snap_q;
  logic        prog_stop_q, tx_overflow_q, io_full_q;

  region_e     rg;
  logic [2:0]  io_off;
  logic        acc_rd, acc_wr, uart_sel, clk_sel, stop_wr, uart_push, ovf_set;
  logic        fifo_push, fifo_full, fifo_empty;
  logic [7:0]  fifo_wdata, clk_byte;
  logic [CW-1:0] fifo_count, free_slots;
  logic        unused_bits;

  assign unused_bits = ^bus.bus_a[31:18];

  assign rg       = decode_region(bus.bus_a[17:16]);
  assign io_off   = bus.bus_a[2:0];
  assign acc_rd   = bus.rdy_in & ~bus.bus_wr;
  assign acc_wr   = bus.rdy_in & bus.bus_wr;
  assign uart_sel = (rg == RG_IO) && (io_off == IO_UART);
  assign clk_sel  = (rg == RG_IO) && io_off[2];
  assign stop_wr  = acc_wr && (rg == RG_IO) && (io_off == IO_CLK);

  // Null bytes from the CPU are filtered; the stop marker bypasses the filter.
  assign uart_push  = acc_wr & uart_sel & ~prog_stop_q & (bus.bus_wdata != 8'h00);
  assign ovf_set    = uart_push & fifo_full;
  assign fifo_push  = uart_push | stop_wr;
  assign fifo_wdata = stop_wr ? 8'h00 : bus.bus_wdata;

  tx_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (bus.tx_ready),
    .data_o      (bus.tx_data),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign free_slots = DEPTH_C - fifo_count;

  // The RX pop must coincide with the address cycle, so this one is combinational.
  assign bus.rx_ready = rst_in & acc_rd & uart_sel & bus.rx_valid;

  // Offset 4 returns the live count (it is being snapshotted); 5..7 come from the snapshot.
  always_comb begin
    clk_byte = cnt_q[7:0];
    case (io_off[1:0])
      2'd1:    clk_byte = snap_q[15:8];
      2'd2:    clk_byte = snap_q[23:16];
      2'd3:    clk_byte = snap_q[31:24];
      default: clk_byte = cnt_q[7:0];
    endcase
  end

  always_comb begin
    rs_d = RS_ZERO;
    io_d = 8'h00;
    if (rg == RG_RAM) begin
      rs_d = RS_RAM;
    end else if (uart_sel && bus.rx_valid) begin
      rs_d = RS_RX;
      io_d = bus.rx_data;
    end else if (clk_sel) begin
      rs_d = RS_CLK;
      io_d = clk_byte;
    end
  end

  // Single-port RAM; the read register only loads on RAM reads so bus_rdata holds between reads.
  always_ff @(posedge clk_in) begin
    if (acc_wr && rg == RG_RAM) ram_mem[bus.bus_a[RAM_AW-1:0]] <= bus.bus_wdata;
    if (acc_rd && rg == RG_RAM) ram_rd_q <= ram_mem[bus.bus_a[RAM_AW-1:0]];
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rs_q          <= RS_ZERO;
      io_q          <= 8'h00;
      cnt_q         <= '0;
      snap_q        <= '0;
      prog_stop_q   <= 1'b0;
      tx_overflow_q <= 1'b0;
      io_full_q     <= 1'b0;
    end else begin
      if (bus.rdy_in) cnt_q <= cnt_q + 32'd1;
      if (acc_rd) begin
        rs_q <= rs_d;
        io_q <= io_d;
      end
      if (acc_rd && clk_sel && io_off[1:0] == 2'd0) snap_q <= cnt_q;
      if (stop_wr) prog_stop_q <= 1'b1;
      if (ovf_set) tx_overflow_q <= 1'b1;
      // Registered, so it trails the count by a cycle; the margin absorbs the in-flight write.
      io_full_q <= (free_slots <= MARGIN_C);
    end
  end

  assign bus.bus_rdata      = (rs_q == RS_RAM) ? ram_rd_q :
                              (rs_q == RS_ZERO) ? 8'h00 : io_q;
  assign bus.tx_valid       = ~fifo_empty;
  assign bus.io_buffer_full = io_full_q;
  assign bus.prog_stop      = prog_stop_q;
  assign bus.tx_overflow    = tx_overflow_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - self-checking bench for mem_io_responder
module tb_mem_io_responder;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  always #5 clk_in = ~clk_in;

  mem_io_responder_if bus();

  mem_io_responder #(.RAM_AW(17), .TX_DEPTH(16), .FULL_MARGIN(2)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  byte unsigned ram_m [int];
  byte unsigned fifo_m [$];
  logic [31:0]  cnt_m, snap_m;
  logic [7:0]   rdata_m;
  bit           stop_m, ovf_m, iobf_m;
  int           pool [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fifo_m.delete();
    cnt_m = 0; snap_m = 0; rdata_m = 0;
    stop_m = 0; ovf_m = 0; iobf_m = 0;
  endtask

  // Behaviour of one clock edge given the inputs held during the cycle.
  task automatic model_edge(input bit rdy, input bit wr, input logic [31:0] a, input logic [7:0] wd);
    int n;
    bit is_io, is_ram;
    n      = fifo_m.size();
    is_io  = (a[17:16] == 2'b11);
    is_ram = (a[17] == 1'b0);
    if (n > 0 && bus.tx_ready) void'(fifo_m.pop_front());
    if (rdy && !wr) begin
      if (is_ram) rdata_m = ram_m[int'(a[16:0])];
      else if (!is_io) rdata_m = 8'h00;
      else begin
        case (a[2:0])
          3'd0: rdata_m = bus.rx_valid ? bus.rx_data : 8'h00;
          3'd4: begin snap_m = cnt_m; rdata_m = cnt_m[7:0]; end
          3'd5: rdata_m = snap_m[15:8];
          3'd6: rdata_m = snap_m[23:16];
          3'd7: rdata_m = snap_m[31:24];
          default: rdata_m = 8'h00;
        endcase
      end
    end
    if (rdy && wr) begin
      if (is_ram) ram_m[int'(a[16:0])] = wd;
      else if (is_io && a[2:0] == 3'd0 && !stop_m && wd != 8'h00) begin
        if (n == 16) ovf_m = 1;
        else fifo_m.push_back(wd);
      end else if (is_io && a[2:0] == 3'd4) begin
        if (n < 16) fifo_m.push_back(8'h00);
        stop_m = 1;
      end
    end
    iobf_m = (16 - n) <= 2;
    if (rdy) cnt_m = cnt_m + 1;
  endtask

  task automatic check_outputs();
    check_eq("bus_rdata", bus.bus_rdata, rdata_m);
    check_eq("tx_valid", bus.tx_valid, fifo_m.size() != 0);
    if (fifo_m.size() != 0) check_eq("tx_data", bus.tx_data, fifo_m[0]);
    check_eq("io_buffer_full", bus.io_buffer_full, iobf_m);
    check_eq("prog_stop", bus.prog_stop, stop_m);
    check_eq("tx_overflow", bus.tx_overflow, ovf_m);
  endtask

  // Called at posedge+1; drives one bus cycle and checks outputs at the next posedge+1.
  task automatic cycle(input bit rdy, input bit wr, input logic [31:0] a, input logic [7:0] wd);
    bus.rdy_in = rdy; bus.bus_wr = wr; bus.bus_a = a; bus.bus_wdata = wd;
    #1;
    check_eq("rx_ready", bus.rx_ready,
             rdy && !wr && a[17:16] == 2'b11 && a[2:0] == 3'd0 && bus.rx_valid);
    model_edge(rdy, wr, a, wd);
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d); cycle(1'b1, 1'b1, a, d); endtask
  task automatic rd(input logic [31:0] a); cycle(1'b1, 1'b0, a, 8'h00); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    bus.rdy_in = 0; bus.bus_wr = 0; bus.bus_a = 0; bus.bus_wdata = 0;
    bus.tx_ready = 0; bus.rx_valid = 0; bus.rx_data = 0;
    model_reset();
    #2;
    check_eq("rst_bus_rdata", bus.bus_rdata, 8'h00);
    check_eq("rst_tx_valid", bus.tx_valid, 1'b0);
    check_eq("rst_rx_ready", bus.rx_ready, 1'b0);
    check_eq("rst_prog_stop", bus.prog_stop, 1'b0);
    check_eq("rst_tx_overflow", bus.tx_overflow, 1'b0);
    check_eq("rst_io_buffer_full", bus.io_buffer_full, 1'b0);
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // Counter: 100 active cycles, then snapshot read of all four bytes.
    for (int i = 0; i < 100; i++) rd(32'h0002_0000);
    rd(32'h0003_0004); v[7:0]   = bus.bus_rdata;
    rd(32'h0003_0005); v[15:8]  = bus.bus_rdata;
    rd(32'h0003_0006); v[23:16] = bus.bus_rdata;
    rd(32'h0003_0007); v[31:24] = bus.bus_rdata;
    check_eq("t4_counter_100", v, 32'd100);
    idle(20);
    rd(32'h0003_0004);
    check_eq("t4_counter_frozen", bus.bus_rdata, 8'd104);

    // RAM write then read.
    wr(32'h0000_0010, 8'hA5);
    rd(32'h0000_0010);
    check_eq("t1_ram_read", bus.bus_rdata, 8'hA5);

    // UART writes with null filtered, then drain.
    bus.tx_ready = 0;
    wr(32'h0003_0000, 8'h48); wr(32'h0003_0000, 8'h69); wr(32'h0003_0000, 8'h00);
    check_eq("t2_valid", bus.tx_valid, 1'b1);
    check_eq("t2_head_H", bus.tx_data, 8'h48);
    bus.tx_ready = 1;
    idle(1);
    check_eq("t2_head_i", bus.tx_data, 8'h69);
    idle(1);
    check_eq("t2_empty", bus.tx_valid, 1'b0);

    // Fill to full and overflow.
    bus.tx_ready = 0;
    for (int k = 1; k <= 17; k++) begin
      wr(32'h0003_0000, 8'(8'h40 + k));
      if (k == 14) check_eq("t3_not_full_yet", bus.io_buffer_full, 1'b0);
      if (k == 15) check_eq("t3_near_full", bus.io_buffer_full, 1'b1);
      if (k == 16) check_eq("t3_no_ovf_yet", bus.tx_overflow, 1'b0);
    end
    check_eq("t3_overflow", bus.tx_overflow, 1'b1);
    bus.tx_ready = 1;
    idle(18);
    check_eq("t3_drained", bus.tx_valid, 1'b0);
    check_eq("t3_iobf_clear", bus.io_buffer_full, 1'b0);

    // RX pass-through.
    bus.rx_valid = 1; bus.rx_data = 8'h37;
    rd(32'h0003_0000);
    check_eq("t5_rx_byte", bus.bus_rdata, 8'h37);
    bus.rx_valid = 0;
    rd(32'h0003_0000);
    check_eq("t5_rx_none", bus.bus_rdata, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 8; i++) begin
      pool[i] = int'($urandom_range(0, 32'h1FFFF));
      wr(32'(pool[i]), 8'($urandom));
    end
    for (int i = 0; i < 1500; i++) begin
      automatic bit rdy = ($urandom_range(0, 9) != 0);
      automatic bit w   = $urandom_range(0, 1) == 1;
      automatic logic [13:0] hi = 14'($urandom);
      automatic logic [7:0]  d  = 8'($urandom);
      automatic int op = int'($urandom_range(0, 7));
      automatic logic [17:0] lo;
      bus.tx_ready = ($urandom_range(0, 99) < ((i < 750) ? 10 : 50));
      bus.rx_valid = $urandom_range(0, 1) == 1;
      bus.rx_data  = 8'($urandom);
      case (op)
        0: begin lo = 18'(pool[$urandom_range(0, 7)]); w = 1; end
        1: begin lo = 18'(pool[$urandom_range(0, 7)]); w = 0; end
        2, 3: begin lo = 18'h30000; w = 1; if ($urandom_range(0, 4) == 0) d = 8'h00; end
        4: begin lo = 18'h30000; w = 0; end
        5: begin lo = 18'(18'h30004 + $urandom_range(0, 3)); w = 0; end
        6: lo = {2'b10, 16'($urandom)};
        default: lo = {2'b11, 13'($urandom), 3'($urandom_range(1, 3))};
      endcase
      cycle(rdy, w, {hi, lo}, d);
    end
    bus.rx_valid = 0;
    bus.tx_ready = 1;
    idle(20);

    // Stop port, then asynchronous reset mid-drain.
    bus.tx_ready = 0;
    wr(32'h0003_0004, 8'h5A);
    check_eq("t6_prog_stop", bus.prog_stop, 1'b1);
    check_eq("t6_stop_byte", bus.tx_data, 8'h00);
    wr(32'h0003_0000, 8'h5A);
    wr(32'h0003_0004, 8'h11);
    bus.tx_ready = 1;
    idle(1);
    check_eq("t6_draining", bus.tx_valid, 1'b1);
    #3;
    rst_in = 1'b0;
    #1;
    check_eq("t6_async_tx_valid", bus.tx_valid, 1'b0);
    check_eq("t6_async_prog_stop", bus.prog_stop, 1'b0);
    check_eq("t6_async_bus_rdata", bus.bus_rdata, 8'h00);
    check_eq("t6_async_overflow", bus.tx_overflow, 1'b0);
    check_eq("t6_async_iobf", bus.io_buffer_full, 1'b0);
    check_eq("t6_async_rx_ready", bus.rx_ready, 1'b0);
    model_reset();
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    bus.tx_ready = 0;
    wr(32'h0003_0000, 8'h51);
    check_eq("t6_uart_after_reset", bus.tx_data, 8'h51);
    rd(32'h0003_0004);
    check_eq("t6_counter_after_reset", bus.bus_rdata, 8'd1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
